c2_serial_decoder: RTL and testbench
====================================

Name: c2_serial_decoder

Overview:
- Inverse of the team's two's-complement negator: takes a WIDTH-bit two's-complement word and returns sign plus unsigned magnitude.
- Computes bit-serially, LSB first, using the copy-to-first-1-then-invert rule. One bit per clock, so the ALU path needs no WIDTH-wide adder chain.
- Sits between the ALU result bus and the display/sign-magnitude consumers.
- Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 6, bits in the input word including the sign bit; also the magnitude width, so the most negative value is representable. Legal range is 2..16.
- CW, 5, width of the bit counter; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data holds a word to convert
- in_ready  output  1  block can accept a word (high only in IDLE)
- in_data  input  WIDTH  two's-complement word
- out_valid  output  1  out_sign/out_mag/out_zero hold a result
- out_ready  input  1  consumer takes the result
- out_sign  output  1  1 = input was negative
- out_mag  output  WIDTH  unsigned magnitude |in_data|
- out_zero  output  1  magnitude is zero
- busy  output  1  high in SHIFT

Behaviour:
- Reset (async, any state, including mid-SHIFT):
  - State = IDLE; shift reg, result reg, counter and seen_one flag all 0.
  - out_valid=0, out_sign=0, out_mag=0, out_zero=0, busy=0, in_ready=1.
  - Any in-flight word is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load shift reg <- in_data, sign reg <- in_data[WIDTH-1], counter <- 0, seen_one <- 0, result reg <- 0, go to SHIFT.
  - in_valid=0: stay in IDLE.
- SHIFT (one bit per edge, LSB first):
  - b = shift reg[0].
  - Output bit r: if sign=0, r=b. If sign=1, r = b while seen_one=0, else r = ~b.
  - seen_one <- seen_one | b.
  - r enters the result reg from the MSB side (right shift), so after WIDTH edges result[i] = r for bit i.
  - shift reg >>= 1; counter++.
  - When counter == WIDTH-1 at the edge, the last bit is processed and the next state is DONE.
  - in_ready=0 and in_valid is ignored.
- DONE:
  - out_valid=1, out_mag = result reg, out_sign = sign reg, out_zero = (result reg == 0).
  - Outputs stay stable while out_ready=0 (unbounded backpressure).
  - Edge with out_ready=1: go to IDLE, out_valid drops next cycle.
  - in_ready=0 in DONE, so no accept on the same edge as the output handshake.
- Latency: accept at edge T, out_valid first high after edge T+WIDTH, i.e. WIDTH cycles.
- Throughput: one word per WIDTH+2 cycles at best (accept edge, WIDTH shift edges, output handshake edge).
- Arithmetic:
  - sign=0: out_mag = in_data.
  - sign=1: out_mag = 2^WIDTH - in_data.
  - Most negative input (1 followed by zeros) gives out_sign=1, out_mag = 1 followed by zeros (no overflow).
  - Input 0 gives sign=0, mag=0, out_zero=1.
- out_ready while out_valid=0 has no effect. in_data is sampled only on the accept edge; changes afterwards do not affect the result.
- All outputs come from registers or state decode; no combinational path from inputs to outputs except in_ready, which depends on state only.

Test Plan:
- Reset, then in_data=6'b000101 with in_valid=1 for one cycle -> exactly 6 cycles later out_valid=1, out_sign=0, out_mag=6'b000101, out_zero=0.
- in_data=6'b111111 (-1) -> out_sign=1, out_mag=6'b000001.
- in_data=6'b111011 (-5) -> out_sign=1, out_mag=6'b000101.
- in_data=6'b100000 (-32) -> out_sign=1, out_mag=6'b100000.
- in_data=0 -> out_sign=0, out_mag=0, out_zero=1.
- Backpressure and in_valid ignored outside IDLE:
  - Hold out_ready=0 for 10 cycles after out_valid -> outputs constant, in_ready=0.
  - Toggle in_valid with new in_data during SHIFT/DONE -> ignored.
  - out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Assert reset on the 3rd SHIFT cycle of -5 -> next cycle IDLE, all outputs 0, in_ready=1.
  - Then convert 6'b011111 -> out_mag=6'b011111, out_sign=0.
- Exhaustive sweep of all 64 values with out_ready tied 1 -> each result matches the |x| reference model.
  - Feeding out_mag back through the existing 5-bit negator, for negative inputs, returns the original low bits.

Source files
------------

// File: rtl/c2_serial_decoder_if.sv
// Handshake bundle for the serial two's-complement to sign/magnitude decoder.
interface c2_serial_decoder_if #(
   parameter int WIDTH = 6
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_sign;
   logic [WIDTH-1:0] out_mag;
   logic             out_zero;
   logic             busy;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sign, out_mag, out_zero, busy
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sign, out_mag, out_zero, busy
   );
endinterface

// File: rtl/c2_serial_decoder.sv
// Bit-serial two's-complement to sign/magnitude converter, LSB first,
// using copy-up-to-first-1-then-invert; one bit per clock.
module c2_serial_decoder #(
   parameter int WIDTH = 6,
   parameter int CW    = 5
) (
   input logic            clk,
   input logic            reset,
   c2_serial_decoder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sh, res, mag_q;
   logic [CW-1:0]    cnt;
   logic             sgn, seen, vld_q, sign_q, zero_q, busy_q;
   logic             b, r;
   logic [WIDTH-1:0] res_nxt;

   // Negative words pass bits unchanged up to and including the first 1,
   // then invert every bit after it.
   always_comb begin
      b       = sh[0];
      r       = b ^ (sgn & seen);
      res_nxt = {r, res[WIDTH-1:1]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         sh     <= '0;
         res    <= '0;
         mag_q  <= '0;
         cnt    <= '0;
         sgn    <= 1'b0;
         seen   <= 1'b0;
         vld_q  <= 1'b0;
         sign_q <= 1'b0;
         zero_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               sh     <= bus.in_data;
               sgn    <= bus.in_data[WIDTH-1];
               cnt    <= '0;
               seen   <= 1'b0;
               res    <= '0;
               busy_q <= 1'b1;
               state  <= SHIFT;
            end
            SHIFT: begin
               res  <= res_nxt;
               seen <= seen | b;
               sh   <= sh >> 1;
               cnt  <= cnt + 1'b1;
               // Results are captured from res_nxt so they are valid on DONE entry.
               if (cnt == CW'(WIDTH-1)) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  vld_q  <= 1'b1;
                  mag_q  <= res_nxt;
                  sign_q <= sgn;
                  zero_q <= (res_nxt == '0);
               end
            end
            DONE: if (bus.out_ready) begin
               vld_q <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = vld_q;
   assign bus.out_sign  = sign_q;
   assign bus.out_mag   = mag_q;
   assign bus.out_zero  = zero_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_c2_serial_decoder.sv
// Scoreboard bench for c2_serial_decoder: expected results are queued on accept
// and compared when the output handshake happens.
module tb_c2_serial_decoder;
   localparam int WIDTH = 6;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic             sign;
      logic [WIDTH-1:0] mag;
      logic             zero;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   c2_serial_decoder_if #(.WIDTH(WIDTH)) bus ();

   c2_serial_decoder #(.WIDTH(WIDTH), .CW(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] x);
      exp_t       e;
      logic [6:0] t;
      t      = 7'd64 - {1'b0, x};
      e.d    = x;
      e.sign = x[WIDTH-1];
      e.mag  = e.sign ? t[5:0] : x;
      e.zero = (e.mag == '0);
      return e;
   endfunction

   function automatic logic [4:0] neg5(input logic [4:0] m);
      return 5'(~m + 5'd1);
   endfunction

   // Caller is positioned just after a rising edge.
   task automatic send(input logic [WIDTH-1:0] d);
      int g = 0;
      while (!bus.in_ready && g < 50) begin
         @(posedge clk); #1; g++;
      end
      if (!bus.in_ready) begin
         chk("send_timeout", 32'(0), 32'(1));
         return;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(posedge clk);
      q.push_back(model(d));
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (q.size() != 0 && g < 50) begin
         @(posedge clk); #1; g++;
      end
      chk("drain", 32'(q.size()), 32'(0));
   endtask

   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) chk("unexpected_out", 32'(1), 32'(0));
         else begin
            exp_t e;
            e = q.pop_front();
            chk("sign", 32'(bus.out_sign), 32'(e.sign));
            chk("mag", 32'(bus.out_mag), 32'(e.mag));
            chk("zero", 32'(bus.out_zero), 32'(e.zero));
            if (e.d[WIDTH-1])
               chk("neg5_back", 32'(neg5(bus.out_mag[4:0])), 32'(e.d[4:0]));
         end
      end
   end

   initial begin
      int n;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vld", 32'(bus.out_valid), 32'(0));
      chk("rst_mag", 32'(bus.out_mag), 32'(0));
      chk("rst_sign", 32'(bus.out_sign), 32'(0));
      chk("rst_zero", 32'(bus.out_zero), 32'(0));
      chk("rst_busy", 32'(bus.busy), 32'(0));
      chk("rst_rdy", 32'(bus.in_ready), 32'(1));
      reset = 1'b0;
      @(posedge clk); #1;

      // First word: latency and busy/ready during SHIFT
      send(6'b000101);
      chk("shift_busy", 32'(bus.busy), 32'(1));
      chk("shift_rdy", 32'(bus.in_ready), 32'(0));
      n = 0;
      while (n < 20) begin
         @(posedge clk); n++; #1;
         if (bus.out_valid) break;
      end
      chk("latency", 32'(n), 32'(WIDTH));
      drain();

      send(6'b111111); drain();
      send(6'b111011); drain();
      send(6'b100000); drain();
      send(6'b000000); drain();

      // Backpressure with junk on the input side
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      send(6'b111011);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         bus.in_valid = ~bus.in_valid;
         bus.in_data  = 6'($urandom);
         @(posedge clk); #1; n++;
      end
      chk("bp_reach", 32'(bus.out_valid), 32'(1));
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = ~bus.in_valid;
         bus.in_data  = 6'($urandom);
         @(posedge clk); #1;
         chk("bp_vld", 32'(bus.out_valid), 32'(1));
         chk("bp_mag", 32'(bus.out_mag), 32'(6'b000101));
         chk("bp_sign", 32'(bus.out_sign), 32'(1));
         chk("bp_rdy", 32'(bus.in_ready), 32'(0));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("hs_vld", 32'(bus.out_valid), 32'(0));
      chk("hs_rdy", 32'(bus.in_ready), 32'(1));
      chk("hs_q", 32'(q.size()), 32'(0));

      // Reset in the middle of SHIFT
      send(6'b111011);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("mid_vld", 32'(bus.out_valid), 32'(0));
      chk("mid_mag", 32'(bus.out_mag), 32'(0));
      chk("mid_sign", 32'(bus.out_sign), 32'(0));
      chk("mid_zero", 32'(bus.out_zero), 32'(0));
      chk("mid_busy", 32'(bus.busy), 32'(0));
      chk("mid_rdy", 32'(bus.in_ready), 32'(1));
      q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      send(6'b011111); drain();

      // Exhaustive sweep
      for (int v = 0; v < 64; v++) begin
         send(6'(v));
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
